instruction_fetch: RTL



---
 rtl/instruction_fetch_if.sv | 29 ++
 rtl/instruction_fetch.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
//
// Purpose : Instruction-memory read bus between the fetch stage and the
//           instruction memory. The memory answers combinationally: the word
//           for `addr` is valid on `instr` in the same cycle.
//
// Signals : addr  [31:0]  word index presented by the fetch stage
//           instr [31:0]  word returned by the memory for `addr`
//
// Modports: master - fetch stage (drives addr, consumes instr)
//           slave  - instruction memory (consumes addr, drives instr)
// -----------------------------------------------------------------------------
interface instruction_fetch_if;

   logic [31:0] addr;
   logic [31:0] instr;

   modport master (
      output addr,
      input  instr
   );

   modport slave (
      input  addr,
      output instr
   );

endinterface : instruction_fetch_if

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Purpose : Fetch stage of the single-issue MIPS pipeline. Holds the PC,
//           presents it as a word index to the instruction memory, and
//           registers the returned word together with its PC into the IF/ID
//           pipeline register. Supports stall, branch/jump redirect with a
//           single bubble, and a counter of instructions delivered valid.
//
// Parameters:
//   MEM_WORDS  - number of instruction words in the attached memory
//   RESET_PC   - word index loaded into the PC on reset
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   synchronous, active-low reset
//   start        in   leave IDLE and begin fetching (ignored outside IDLE)
//   stall        in   hold PC and IF/ID this cycle
//   redirect     in   load redirect_pc and squash the in-flight fetch
//   redirect_pc  in   new word index from the branch/jump logic
//   imem         if   instruction-memory bus (master side)
//   if_instr     out  IF/ID instruction register
//   if_pc        out  IF/ID PC register (word index of if_instr)
//   if_valid     out  IF/ID holds a real instruction (0 = bubble)
//   fetch_count  out  instructions delivered with if_valid = 1
//   fetch_fault  out  sticky out-of-range fault (bounds-check build only)
//
// Configuration:
//   IFETCH_BOUNDS_CHECK_EN - when defined, an advance with PC >= MEM_WORDS
//   performs no fetch, raises the sticky fetch_fault and parks the stage in
//   HALT until reset. When undefined, the PC is passed through unchecked and
//   range handling is left to the memory.
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter int unsigned MEM_WORDS = 32,
   parameter logic [31:0] RESET_PC  = 32'd0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic [31:0]          redirect_pc,
   instruction_fetch_if.master  imem,
   output logic [31:0]          if_instr,
   output logic [31:0]          if_pc,
   output logic                 if_valid,
   output logic [31:0]          fetch_count
`ifdef IFETCH_BOUNDS_CHECK_EN
   ,
   output logic                 fetch_fault
`endif
);

   // An empty instruction memory is a configuration error, caught at
   // elaboration rather than showing up as a permanent fault.
   if (MEM_WORDS == 0) begin : g_bad_mem_words
      $error("instruction_fetch: MEM_WORDS must be non-zero");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   // All 32-bit zero: a MIPS "sll $0,$0,0", used as the bubble encoding.
   localparam logic [31:0] NOP = 32'd0;

   state_t      state_q,       state_d;
   logic [31:0] pc_q,          pc_d;
   logic [31:0] if_instr_q,    if_instr_d;
   logic [31:0] if_pc_q,       if_pc_d;
   logic        if_valid_q,    if_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;

`ifdef IFETCH_BOUNDS_CHECK_EN
   localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

   logic        fault_q, fault_d;
   logic        pc_out_of_range;

   assign pc_out_of_range = (pc_q >= MEM_LIMIT);
`endif

   // ---------------------------------------------------------------------------
   // Next-state / next-output logic.
   // Priority inside RUN: redirect > stall > advance. Reset is handled in the
   // register process and overrides everything here.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal is given its "hold" value first, so no path through
      // the case/if tree can leave one unassigned and infer a latch.
      state_d       = state_q;
      pc_d          = pc_q;
      if_instr_d    = if_instr_q;
      if_pc_d       = if_pc_q;
      if_valid_d    = if_valid_q;
      fetch_count_d = fetch_count_q;
`ifdef IFETCH_BOUNDS_CHECK_EN
      fault_d       = fault_q;
`endif

      unique case (state_q)
         IDLE: begin
            // PC and IF/ID stay at their reset values; if_valid is already 0.
            if (start) begin
               state_d = RUN;
            end
         end

         RUN: begin
            if (redirect) begin
               // Squash whatever was being fetched; the new target is
               // presented to memory next cycle and delivered one edge later,
               // giving exactly one bubble. Redirect overrides stall.
               pc_d       = redirect_pc;
               if_valid_d = 1'b0;
               if_instr_d = NOP;
            end else if (!stall) begin
`ifdef IFETCH_BOUNDS_CHECK_EN
               if (pc_out_of_range) begin
                  // No fetch from outside the memory: bubble, latch the
                  // fault and park. PC keeps the faulting index for debug.
                  if_valid_d = 1'b0;
                  fault_d    = 1'b1;
                  state_d    = HALT;
               end else begin
                  if_instr_d    = imem.instr;
                  if_pc_d       = pc_q;
                  if_valid_d    = 1'b1;
                  pc_d          = pc_q + 32'd1;
                  fetch_count_d = fetch_count_q + 32'd1;
               end
`else
               // Both increments wrap naturally at 2^32.
               if_instr_d    = imem.instr;
               if_pc_d       = pc_q;
               if_valid_d    = 1'b1;
               pc_d          = pc_q + 32'd1;
               fetch_count_d = fetch_count_q + 32'd1;
`endif
            end
            // stall without redirect: every register holds (defaults).
         end

         HALT: begin
            // Terminal until reset; start and redirect are ignored.
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and pipeline registers.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge (synchronous). Every flop here
      // is a control or datapath register, not a storage array, so all of
      // them get a defined reset value and a mid-run reset discards the
      // complete pipeline state in a single edge.
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         if_instr_q    <= NOP;
         if_pc_q       <= 32'd0;
         if_valid_q    <= 1'b0;
         fetch_count_q <= 32'd0;
`ifdef IFETCH_BOUNDS_CHECK_EN
         fault_q       <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments, so every register samples the
         // pre-edge values computed above regardless of statement order.
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_instr_q    <= if_instr_d;
         if_pc_q       <= if_pc_d;
         if_valid_q    <= if_valid_d;
         fetch_count_q <= fetch_count_d;
`ifdef IFETCH_BOUNDS_CHECK_EN
         fault_q       <= fault_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. imem.addr is a straight wire from the PC register so the memory
   // sees the full cycle for its combinational read.
   // ---------------------------------------------------------------------------
   assign imem.addr   = pc_q;
   assign if_instr    = if_instr_q;
   assign if_pc       = if_pc_q;
   assign if_valid    = if_valid_q;
   assign fetch_count = fetch_count_q;
`ifdef IFETCH_BOUNDS_CHECK_EN
   assign fetch_fault = fault_q;
`endif

endmodule : instruction_fetch
